bottleneck_bridge: RTL and testbench

BOTTLENECK_BRIDGE -- requirements
Module: bottleneck_bridge

---
 rtl/bottleneck_bridge.sv | 155 +++++++++++++++
 tb/tb_bottleneck_bridge.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bottleneck_bridge.sv
// ---------------------------------------------------------------------------
// bottleneck_bridge
//
// Splits one master access (8/16/32/64 bit, right-justified data) into a
// sequence of narrower slave beats of SW = 8<<SSIZ bits. Beats are issued
// highest address offset first. Read data is gathered into a hold register
// and returned, sign- or zero-extended, in the same cycle as the final slave
// acknowledge.
//
// Handshake: a request is MCycI & MStbI with ResetI low. While the request is
// held and aligned, SStbO stays high for the current beat until SAckI or
// SErrI arrives. SErrI wins over SAckI and ends the transfer with MErrBusO.
// MAckO pulses combinationally with the final SAckI. Dropping the request
// abandons the transfer.
//
// Ports
//   ClkI, ResetI          clock, synchronous active-high reset
//   MCycI, MStbI          master request qualifiers
//   MWeI, MSignedI        write enable, signed read extension
//   MSizI                 access size: 0=8, 1=16, 2=32, 3=64 bit
//   MAdrI, MDatI          byte address, right-justified write data
//   MDatO, MAckO          read data (0 unless MAckO), transfer done
//   MErrAlignO            address not aligned to MSizI
//   MErrBusO              slave reported an error
//   SStbO, SWeO, SSignedO, SSizO, SAdrO, SDatO   slave beat request
//   SDatI, SAckI, SErrI   slave response
// ---------------------------------------------------------------------------
module bottleneck_bridge #(
    parameter int AW   = 64,
    parameter int SSIZ = 1
) (
    input  logic                    ClkI,
    input  logic                    ResetI,
    input  logic                    MCycI,
    input  logic                    MStbI,
    input  logic                    MWeI,
    input  logic                    MSignedI,
    input  logic [1:0]              MSizI,
    input  logic [AW-1:0]           MAdrI,
    input  logic [63:0]             MDatI,
    output logic [63:0]             MDatO,
    output logic                    MAckO,
    output logic                    MErrAlignO,
    output logic                    MErrBusO,
    output logic                    SStbO,
    output logic                    SWeO,
    output logic                    SSignedO,
    output logic [1:0]              SSizO,
    output logic [AW-1:0]           SAdrO,
    output logic [(8<<SSIZ)-1:0]    SDatO,
    input  logic [(8<<SSIZ)-1:0]    SDatI,
    input  logic                    SAckI,
    input  logic                    SErrI
);

    localparam int          SW        = 8 << SSIZ;
    localparam logic [1:0]  SSIZ_L    = 2'(SSIZ);
    localparam logic [63:0] LANE_MASK = {64{1'b1}} >> (64 - SW);

    logic        w_req;
    logic        w_misalign;
    logic        w_act;
    logic        w_final;
    logic [2:0]  w_alnmask;
    logic [1:0]  w_esz;
    logic [1:0]  w_lg;
    logic [2:0]  w_nm1;
    logic [2:0]  w_k;
    logic [8:0]  w_boff;
    logic [63:0] w_asm;
    logic [63:0] w_rd;

    logic [2:0]  r_cnt;
    logic [63:0] r_hold;

    assign w_req = MCycI & MStbI & ~ResetI;

    always_comb begin
        w_alnmask = 3'd0;
        case (MSizI)
            2'd0:    w_alnmask = 3'd0;
            2'd1:    w_alnmask = 3'd1;
            2'd2:    w_alnmask = 3'd3;
            default: w_alnmask = 3'd7;
        endcase
    end

    assign w_misalign = |(MAdrI[2:0] & w_alnmask);
    assign w_act      = w_req & ~w_misalign;

    // Effective element size: the wider of the access and the slave port.
    assign w_esz = (MSizI > SSIZ_L) ? MSizI : SSIZ_L;
    assign w_lg  = w_esz - SSIZ_L;

    always_comb begin
        w_nm1 = 3'd0;
        case (w_lg)
            2'd0:    w_nm1 = 3'd0;
            2'd1:    w_nm1 = 3'd1;
            2'd2:    w_nm1 = 3'd3;
            default: w_nm1 = 3'd7;
        endcase
    end

    // A size change mid-transfer can leave the counter above N-1; treat that
    // as the final beat so the transfer still terminates and clears.
    assign w_k     = (r_cnt > w_nm1) ? 3'd0 : (w_nm1 - r_cnt);
    assign w_final = (w_k == 3'd0);
    assign w_boff  = 9'(w_k) << (SSIZ + 3);

    assign SStbO    = w_act;
    assign SWeO     = w_act & MWeI;
    assign SSignedO = w_act & MSignedI;
    assign SSizO    = w_act ? ((MSizI < SSIZ_L) ? MSizI : SSIZ_L) : 2'd0;
    assign SAdrO    = w_act ? (MAdrI + (AW'(w_k) << SSIZ)) : '0;
    assign SDatO    = w_act ? SW'(MDatI >> w_boff) : '0;

    assign MErrAlignO = w_req & w_misalign;
    assign MErrBusO   = w_act & SErrI;
    assign MAckO      = w_act & ~SErrI & SAckI & w_final;

    // Upper lanes come from the hold register, lane 0 straight from the slave.
    assign w_asm = (r_hold & ~LANE_MASK) | 64'(SDatI);

    always_comb begin
        w_rd = '0;
        if (MAckO) begin
            case (w_esz)
                2'd0:    w_rd = {{56{MSignedI & w_asm[7]}},  w_asm[7:0]};
                2'd1:    w_rd = {{48{MSignedI & w_asm[15]}}, w_asm[15:0]};
                2'd2:    w_rd = {{32{MSignedI & w_asm[31]}}, w_asm[31:0]};
                default: w_rd = w_asm;
            endcase
        end
    end

    assign MDatO = w_rd;

    always_ff @(posedge ClkI) begin
        if (ResetI) begin
            r_cnt  <= 3'd0;
            r_hold <= '0;
        end else if (!w_act || SErrI) begin
            r_cnt <= 3'd0;
        end else if (SAckI) begin
            if (w_final) begin
                r_cnt <= 3'd0;
            end else begin
                r_cnt  <= r_cnt + 3'd1;
                r_hold <= (r_hold & ~(LANE_MASK << w_boff)) | (64'(SDatI) << w_boff);
            end
        end
    end

endmodule

// File: tb/tb_bottleneck_bridge.sv
// ---------------------------------------------------------------------------
// tb_bottleneck_bridge
//
// Three bridges (SSIZ = 0, 1, 2) share the master inputs; each has its own
// slave response lines. "sel" picks which bridge the current transfer targets
// and which bridge's outputs are observed.
// ---------------------------------------------------------------------------
module tb_bottleneck_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cyc, stb, we, sgn;
    logic [1:0]  siz;
    logic [63:0] adr, mdat;
    logic [2:0]  s_ack, s_err;
    logic [63:0] s_din;

    logic [63:0] mdo [3];
    logic [2:0]  mack, mea, meb, sstb, swe, ssg;
    logic [1:0]  ssz [3];
    logic [63:0] sadr [3];
    logic [7:0]  sdo0;
    logic [15:0] sdo1;
    logic [31:0] sdo2;

    int checks   = 0;
    int failures = 0;
    int sel      = 0;

    bottleneck_bridge #(.AW(64), .SSIZ(0)) u_b0 (
        .ClkI(clk), .ResetI(rst), .MCycI(cyc), .MStbI(stb), .MWeI(we), .MSignedI(sgn),
        .MSizI(siz), .MAdrI(adr), .MDatI(mdat), .MDatO(mdo[0]), .MAckO(mack[0]),
        .MErrAlignO(mea[0]), .MErrBusO(meb[0]), .SStbO(sstb[0]), .SWeO(swe[0]),
        .SSignedO(ssg[0]), .SSizO(ssz[0]), .SAdrO(sadr[0]), .SDatO(sdo0),
        .SDatI(s_din[7:0]), .SAckI(s_ack[0]), .SErrI(s_err[0]));

    bottleneck_bridge #(.AW(64), .SSIZ(1)) u_b1 (
        .ClkI(clk), .ResetI(rst), .MCycI(cyc), .MStbI(stb), .MWeI(we), .MSignedI(sgn),
        .MSizI(siz), .MAdrI(adr), .MDatI(mdat), .MDatO(mdo[1]), .MAckO(mack[1]),
        .MErrAlignO(mea[1]), .MErrBusO(meb[1]), .SStbO(sstb[1]), .SWeO(swe[1]),
        .SSignedO(ssg[1]), .SSizO(ssz[1]), .SAdrO(sadr[1]), .SDatO(sdo1),
        .SDatI(s_din[15:0]), .SAckI(s_ack[1]), .SErrI(s_err[1]));

    bottleneck_bridge #(.AW(64), .SSIZ(2)) u_b2 (
        .ClkI(clk), .ResetI(rst), .MCycI(cyc), .MStbI(stb), .MWeI(we), .MSignedI(sgn),
        .MSizI(siz), .MAdrI(adr), .MDatI(mdat), .MDatO(mdo[2]), .MAckO(mack[2]),
        .MErrAlignO(mea[2]), .MErrBusO(meb[2]), .SStbO(sstb[2]), .SWeO(swe[2]),
        .SSignedO(ssg[2]), .SSizO(ssz[2]), .SAdrO(sadr[2]), .SDatO(sdo2),
        .SDatI(s_din[31:0]), .SAckI(s_ack[2]), .SErrI(s_err[2]));

    // Observed outputs of the selected bridge.
    logic [63:0] o_mdo, o_adr, o_sdo;
    logic        o_ack, o_ea, o_eb, o_stb, o_we, o_sg;
    logic [1:0]  o_sz;

    always_comb begin
        o_mdo = mdo[sel];
        o_adr = sadr[sel];
        o_sz  = ssz[sel];
        o_ack = mack[sel];
        o_ea  = mea[sel];
        o_eb  = meb[sel];
        o_stb = sstb[sel];
        o_we  = swe[sel];
        o_sg  = ssg[sel];
        case (sel)
            0:       o_sdo = {56'd0, sdo0};
            1:       o_sdo = {48'd0, sdo1};
            default: o_sdo = {32'd0, sdo2};
        endcase
    end

    // ---------------- reference model ----------------
    function automatic int nbeats(input int ssiz_i, input int size_i);
        return (size_i > ssiz_i) ? (1 << (size_i - ssiz_i)) : 1;
    endfunction

    // raw holds the whole slave-returned value, lane k at bits k*SW.
    function automatic logic [63:0] expect_read(input int ssiz_i, input int size_i,
                                                input logic s, input logic [63:0] raw);
        int          wb;
        logic [63:0] m;
        logic [63:0] v;
        wb = 8 << ((size_i > ssiz_i) ? size_i : ssiz_i);
        v  = raw;
        if (wb < 64) begin
            m = (64'd1 << wb) - 64'd1;
            v = raw & m;
            if (s && raw[wb-1]) v = v | ~m;
        end
        return v;
    endfunction

    task automatic drive_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sgn = 1'b0; siz = 2'd0;
        adr = '0; mdat = '0; s_ack = '0; s_err = '0; s_din = '0;
    endtask

    // Runs one full transfer on bridge ssiz_i. Beat err_at (sequence position,
    // -1 for none) answers with SErrI. Starts and ends just after a posedge.
    task automatic drive_xfer(input int ssiz_i, input int size_i, input logic [63:0] a,
                              input logic w, input logic s, input logic [63:0] wd,
                              input logic [63:0] rd, input int err_at,
                              input int min_wait, input int max_wait);
        int          n, sw, k, nw;
        logic        last, is_err, ack_both, exp_ack, exp_eb;
        logic [63:0] lm, exp_adr, exp_sdo, exp_md;
        logic [1:0]  exp_sz;
        n      = nbeats(ssiz_i, size_i);
        sw     = 8 << ssiz_i;
        lm     = (64'd1 << sw) - 64'd1;
        exp_sz = (size_i < ssiz_i) ? 2'(size_i) : 2'(ssiz_i);
        sel = ssiz_i;
        cyc = 1'b1; stb = 1'b1; we = w; sgn = s; siz = 2'(size_i); adr = a; mdat = wd;
        for (int j = 0; j < n; j++) begin
            k       = n - 1 - j;
            exp_adr = a + 64'(k << ssiz_i);
            exp_sdo = (wd >> (k * sw)) & lm;
            nw      = $urandom_range(min_wait, max_wait);
            is_err  = (j == err_at);
            for (int c = 0; c <= nw; c++) begin
                last     = (c == nw);
                ack_both = 1'($urandom_range(0, 1));
                s_ack    = '0;
                s_err    = '0;
                s_ack[ssiz_i] = last && (!is_err || ack_both);
                s_err[ssiz_i] = last && is_err;
                s_din    = (rd >> (k * sw)) & lm;
                exp_ack  = last && !is_err && (j == n - 1);
                exp_eb   = last && is_err;
                exp_md   = exp_ack ? expect_read(ssiz_i, size_i, s, rd) : 64'd0;
                @(negedge clk);
                checks++;
                if (o_stb !== 1'b1 || o_ea !== 1'b0) begin
                    failures++;
                    $display("FAIL xfer_strobe beat=%0d: stb=%b ea=%b, want stb=1 ea=0", k, o_stb, o_ea);
                end
                checks++;
                if (o_adr !== exp_adr) begin
                    failures++;
                    $display("FAIL xfer_sadr beat=%0d: got %h want %h", k, o_adr, exp_adr);
                end
                checks++;
                if (o_sdo !== exp_sdo || o_sz !== exp_sz || o_we !== w || o_sg !== s) begin
                    failures++;
                    $display("FAIL xfer_sctl beat=%0d: sdat=%h siz=%0d we=%b sg=%b want %h %0d %b %b",
                             k, o_sdo, o_sz, o_we, o_sg, exp_sdo, exp_sz, w, s);
                end
                checks++;
                if (o_ack !== exp_ack || o_eb !== exp_eb) begin
                    failures++;
                    $display("FAIL xfer_ack beat=%0d: ack=%b eb=%b want ack=%b eb=%b", k, o_ack, o_eb, exp_ack, exp_eb);
                end
                checks++;
                if (o_mdo !== exp_md) begin
                    failures++;
                    $display("FAIL xfer_mdat beat=%0d: got %h want %h", k, o_mdo, exp_md);
                end
                @(posedge clk); #1;
            end
            if (is_err) break;
        end
        s_ack = '0;
        s_err = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        cyc = 1'b1; stb = 1'b1; siz = 2'd3; adr = 64'h100; mdat = 64'h0123_4567_89AB_CDEF;
        s_ack = 3'b111; s_din = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            checks++;
            if ({o_stb, o_ack, o_ea, o_eb, o_we, o_sg} !== 6'b0 || o_adr !== 64'd0 ||
                o_sdo !== 64'd0 || o_mdo !== 64'd0 || o_sz !== 2'd0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d: stb=%b ack=%b adr=%h sdat=%h mdat=%h, want all 0",
                         d, o_stb, o_ack, o_adr, o_sdo, o_mdo);
            end
        end
        drive_idle();
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        // 64-bit read through a 16-bit slave, no wait states.
        drive_xfer(1, 3, 64'h100, 1'b0, 1'b0, 64'd0, 64'hDDDD_CCCC_BBBB_AAAA, -1, 0, 0);
        drive_idle(); @(posedge clk); #1;
        // 32-bit signed and unsigned reads.
        drive_xfer(1, 2, 64'h40, 1'b0, 1'b1, 64'd0, 64'h8001_0002, -1, 0, 0);
        drive_idle(); @(posedge clk); #1;
        drive_xfer(1, 2, 64'h40, 1'b0, 1'b0, 64'd0, 64'h8001_0002, -1, 0, 0);
        drive_idle(); @(posedge clk); #1;
        // 32-bit write with exactly one wait state per beat.
        drive_xfer(1, 2, 64'h10, 1'b1, 1'b0, 64'h1234_5678, 64'd0, -1, 1, 1);
        drive_idle(); @(posedge clk); #1;
    endtask

    task automatic test_misaligned();
        drive_idle();
        sel = 1;
        cyc = 1'b1; stb = 1'b1; siz = 2'd1; adr = 64'h3;
        s_ack = 3'b010; s_din = 64'h5555;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (o_ea !== 1'b1 || o_stb !== 1'b0 || o_ack !== 1'b0 || o_mdo !== 64'd0) begin
                failures++;
                $display("FAIL misaligned cyc=%0d: ea=%b stb=%b ack=%b mdat=%h want 1 0 0 0",
                         c, o_ea, o_stb, o_ack, o_mdo);
            end
            @(posedge clk); #1;
        end
        s_ack = '0;
        // Byte access at the same odd address is legal: a single beat.
        drive_xfer(1, 0, 64'h3, 1'b0, 1'b1, 64'd0, 64'h0000_0000_0000_00F3, -1, 0, 0);
        drive_idle(); @(posedge clk); #1;
    endtask

    task automatic test_bus_error();
        // Error on the second beat, request kept high: the next transfer
        // must restart at the highest beat.
        drive_xfer(1, 3, 64'h2000, 1'b0, 1'b0, 64'd0, 64'h1111_2222_3333_4444, 1, 0, 0);
        drive_xfer(1, 3, 64'h2000, 1'b0, 1'b0, 64'd0, 64'h5555_6666_7777_8888, -1, 0, 1);
        drive_idle(); @(posedge clk); #1;
    endtask

    task automatic test_wide_slaves();
        drive_xfer(0, 3, 64'h300, 1'b0, 1'b0, 64'd0, 64'hF1E2_D3C4_B5A6_9788, -1, 0, 0);
        drive_idle(); @(posedge clk); #1;
        drive_xfer(2, 3, 64'h308, 1'b1, 1'b0, 64'hCAFE_BABE_DEAD_BEEF, 64'h0123_4567_89AB_CDEF, -1, 0, 1);
        drive_idle(); @(posedge clk); #1;
    endtask

    task automatic test_drop();
        drive_idle();
        sel = 2;
        cyc = 1'b1; stb = 1'b1; siz = 2'd3; adr = 64'h200;
        s_ack = 3'b100; s_din = 64'h0000_0000_AAAA_5555;
        @(negedge clk);
        checks++;
        if (o_adr !== 64'h204 || o_stb !== 1'b1) begin
            failures++;
            $display("FAIL drop_first_beat: adr=%h stb=%b want 204 1", o_adr, o_stb);
        end
        @(posedge clk); #1;
        stb = 1'b0;
        @(negedge clk);
        checks++;
        if (o_stb !== 1'b0 || o_ack !== 1'b0 || o_mdo !== 64'd0) begin
            failures++;
            $display("FAIL drop_strobe: stb=%b ack=%b mdat=%h want 0 0 0", o_stb, o_ack, o_mdo);
        end
        @(posedge clk); #1;
        s_ack = '0;
        drive_xfer(2, 3, 64'h200, 1'b0, 1'b1, 64'd0, 64'h8765_4321_0FED_CBA9, -1, 0, 0);
        drive_idle(); @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        drive_idle();
        sel = 0;
        cyc = 1'b1; stb = 1'b1; siz = 2'd3; adr = 64'h80;
        s_ack = 3'b001; s_din = 64'h5A;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_stb !== 1'b0 || o_ack !== 1'b0 || o_eb !== 1'b0 || o_adr !== 64'd0 ||
            o_sdo !== 64'd0 || o_mdo !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid: stb=%b ack=%b adr=%h sdat=%h mdat=%h want all 0",
                     o_stb, o_ack, o_adr, o_sdo, o_mdo);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        s_ack = '0;
        drive_xfer(0, 3, 64'h80, 1'b0, 1'b0, 64'd0, 64'h0102_0304_0506_0708, -1, 0, 0);
        drive_idle(); @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        drive_xfer(1, 2, 64'h500, 1'b1, 1'b0, 64'hAAAA_BBBB, 64'd0, -1, 0, 0);
        drive_xfer(1, 2, 64'h504, 1'b0, 1'b1, 64'd0, 64'hFEDC_BA98, -1, 0, 0);
        drive_idle(); @(posedge clk); #1;
    endtask

    task automatic test_random();
        int          s_i, z_i, n, e;
        logic [63:0] a, wd, rd;
        for (int t = 0; t < 40; t++) begin
            s_i = $urandom_range(0, 2);
            z_i = $urandom_range(0, 3);
            a   = {$urandom, $urandom};
            a   = a & ~64'((1 << z_i) - 1);
            wd  = {$urandom, $urandom};
            rd  = {$urandom, $urandom};
            n   = nbeats(s_i, z_i);
            e   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
            drive_xfer(s_i, z_i, a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       wd, rd, e, 0, 2);
            if ($urandom_range(0, 1) == 1) begin
                drive_idle();
                @(posedge clk); #1;
            end
        end
        drive_idle(); @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_misaligned();
        test_bus_error();
        test_wide_slaves();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
